jlsemi_util_sync_deglitch_multi: RTL and testbench
==================================================

// Module: jlsemi_util_sync_deglitch_multi
// PURPOSE
//  Multi-channel input conditioner: WIDTH asynchronous level inputs each pass through a
//  SYNC_STEP-deep synchroniser, then a programmable per-channel deglitch filter.
//  Outputs are the filtered levels plus single-cycle rise/fall pulses per channel.
//  Sits at the boundary between pads/analog status bits and control logic in the clk domain.
// PARAMETERS
//  WIDTH      4   number of independent channels (>=1)
//  SYNC_STEP  2   synchroniser flop depth per channel (>=2)
//  CNT_W      4   width of filter length / per-channel stability counter (>=1)
//  RST_VAL    0   WIDTH-bit reset value of all sync flops and dout
// PORTS
//  clk        in   1       single clock; all flops on posedge
//  rst        in   1       synchronous reset, active-high
//  din        in   WIDTH   asynchronous level inputs
//  filt_en    in   1       1 = deglitch filter active, 0 = bypass (length forced to 1)
//  filt_len   in   CNT_W   required consecutive differing samples before dout changes
//  dout       out  WIDTH   synchronised, filtered levels
//  rise_pls   out  WIDTH   1-cycle pulse when dout[i] goes 0->1
//  fall_pls   out  WIDTH   1-cycle pulse when dout[i] goes 1->0
// BEHAVIOUR
//  Reset (rst=1 at posedge): sync flops and dout <= RST_VAL; counters <= 0; rise/fall <= 0.
//  Sync: ff[0] <= din[i]; ff[k] <= ff[k-1]; s[i] = ff[SYNC_STEP-1]. No logic between flops.
//  Effective length Leff = (filt_en==0 || filt_len==0) ? 1 : filt_len.
//  Per channel, each cycle (all registered):
//   - s==dout          : cnt <= 0; dout holds.
//   - s!=dout, cnt+1>=Leff : dout <= s; cnt <= 0.
//   - s!=dout, else    : cnt <= cnt+1.
//  So dout changes only after s differs from it on Leff consecutive cycles; any sample
//  equal to dout restarts the count (glitches shorter than Leff are suppressed).
//  Latency: din stable change before edge 1 -> dout updates at edge SYNC_STEP+Leff.
//  Bypass: Leff=1 -> dout = s delayed one cycle (latency SYNC_STEP+1).
//  Edges: rise_pls[i] <= dout_nxt[i] & ~dout[i]; fall_pls[i] <= ~dout_nxt[i] & dout[i];
//   asserted in the same cycle dout shows the new value; exactly one cycle wide;
//   rise and fall never both high for a channel.
//  Counter never exceeds Leff-1, so no wrap; compare uses >= so lowering filt_len
//   mid-count (below cnt+1) commits at the next differing sample; raising it extends count.
//  filt_en/filt_len are quasi-static but changes take effect at the next edge, no glitch.
//  Channels are fully independent; simultaneous changes on several channels are legal.
//  Reset mid-filtering discards counts; no pulses in the cycle after reset release
//   unless a channel then completes a full Leff run.
// STRUCTURE
//  No shared-package typedefs required; CNT_W/RST_VAL remain local parameters.
//  One sub-module: jlsemi_util_deglitch_ch (single-channel counter+dout+edge logic,
//   params CNT_W, RST_BIT); instantiated WIDTH times in a generate loop after the
//   synchroniser array. Synchroniser flops kept in the top for constraint targeting.
// TESTING  (WIDTH=4, SYNC_STEP=2, CNT_W=4, RST_VAL=0 unless stated)
//  1 filt_en=0, din 0->4'b0001 held -> dout[0]=1 and rise_pls[0]=1 at edge 3, pulse 1 cycle.
//  2 filt_en=1, filt_len=3, din[1] high 2 cycles then low -> dout[1] stays 0, no pulses;
//    held 3+ cycles -> dout[1]=1 at edge 5 after change, rise_pls[1] one cycle.
//  3 filt_len=3, dout[2]=1, din[2] low 2 cycles, high 1, low 3 -> single fall_pls[2]
//    only after the 3-cycle run; count restarts on the 1-cycle high.
//  4 filt_len=0 with filt_en=1 -> identical to bypass timing of test 1.
//  5 filt_len=8, cnt at 5, change filt_len to 4 -> dout commits next cycle; raise to
//    15 at cnt 5 -> commits after 15 total samples.
//  6 rst=1 for 1 cycle mid-count with din=4'hF -> all outputs 0 next edge; dout=4'hF
//    SYNC_STEP+Leff edges after release; RST_VAL=4'hA run: dout=4'hA out of reset, no pulses.

Source files
------------

// File: rtl/jlsemi_util_sync_deglitch_multi_pkg.sv
// Shared defaults and helpers for the multi-channel synchronise + deglitch block.
package jlsemi_util_sync_deglitch_multi_pkg;

    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned DEF_SYNC_STEP = 2;
    localparam int unsigned DEF_CNT_W     = 4;

    // Effective filter length: bypass or a zero length both collapse to a single sample.
    function automatic logic [31:0] eff_len(input logic en, input logic [31:0] len);
        if (!en || (len == 32'd0)) begin
            eff_len = 32'd1;
        end else begin
            eff_len = len;
        end
    endfunction

    // Registered edge-pulse helpers: new value versus current value of a level.
    function automatic logic rise_of(input logic nxt, input logic cur);
        rise_of = nxt & ~cur;
    endfunction

    function automatic logic fall_of(input logic nxt, input logic cur);
        fall_of = ~nxt & cur;
    endfunction

endpackage

// File: rtl/jlsemi_util_deglitch_ch.sv
// Single-channel deglitch filter: stability counter, filtered level and edge pulses.
// dout only follows the synchronised sample after it has differed for leff_i
// consecutive cycles; any agreeing sample restarts the count.
module jlsemi_util_deglitch_ch
    import jlsemi_util_sync_deglitch_multi_pkg::*;
#(
    parameter int unsigned CNT_W   = 4,
    parameter logic        RST_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_i,
    input  logic [CNT_W-1:0] leff_i,
    output logic             dout_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic [CNT_W:0]   cnt_inc_s;

    // One extra bit so cnt+1 never wraps before the >= compare against the length.
    assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // Next-state: count differing samples, commit when the run reaches the length.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (s_i != dout_q) begin
            if (cnt_inc_s >= {1'b0, leff_i}) begin
                dout_d = s_i;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                cnt_d  = cnt_inc_s[CNT_W-1:0];
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
        rise_d = rise_of(dout_d, dout_q);
        fall_d = fall_of(dout_d, dout_q);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            dout_q <= RST_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/jlsemi_util_sync_deglitch_multi.sv
// Multi-channel input conditioner: per-channel synchroniser chain followed by a
// programmable deglitch filter with registered rise/fall pulses.
// The synchroniser flops live here (not in the channel) so timing constraints
// can target them as one array.
module jlsemi_util_sync_deglitch_multi
    import jlsemi_util_sync_deglitch_multi_pkg::*;
#(
    parameter int unsigned          WIDTH     = DEF_WIDTH,
    parameter int unsigned          SYNC_STEP = DEF_SYNC_STEP,
    parameter int unsigned          CNT_W     = DEF_CNT_W,
    parameter logic [WIDTH-1:0]     RST_VAL   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             filt_en,
    input  logic [CNT_W-1:0] filt_len,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise_pls,
    output logic [WIDTH-1:0] fall_pls
);

    logic [WIDTH-1:0] sync_q [SYNC_STEP];
    logic [WIDTH-1:0] sync_s;
    logic [CNT_W-1:0] leff_s;
    logic [31:0]      leff_full_s;

    // Synchroniser chain: plain flop-to-flop, no logic between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(SYNC_STEP); k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < int'(SYNC_STEP); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s      = sync_q[SYNC_STEP-1];
    assign leff_full_s = eff_len(filt_en, 32'(filt_len));
    assign leff_s      = leff_full_s[CNT_W-1:0];

    genvar i;
    generate
        for (i = 0; i < int'(WIDTH); i++) begin : g_ch
            jlsemi_util_deglitch_ch #(
                .CNT_W   (CNT_W),
                .RST_BIT (RST_VAL[i])
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .s_i    (sync_s[i]),
                .leff_i (leff_s),
                .dout_o (dout[i]),
                .rise_o (rise_pls[i]),
                .fall_o (fall_pls[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_jlsemi_util_sync_deglitch_multi.sv
// Directed bench for jlsemi_util_sync_deglitch_multi (WIDTH=4, SYNC_STEP=2, CNT_W=4).
// A second instance with RST_VAL=4'hA shares the stimulus for the reset-value check.
module tb_jlsemi_util_sync_deglitch_multi;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       filt_en;
    logic [3:0] filt_len;
    logic [3:0] dout;
    logic [3:0] rise_pls;
    logic [3:0] fall_pls;
    logic [3:0] dout_a;
    logic [3:0] rise_a;
    logic [3:0] fall_a;

    int n_cmp;
    int n_bad;

    jlsemi_util_sync_deglitch_multi #(
        .WIDTH(4), .SYNC_STEP(2), .CNT_W(4), .RST_VAL(4'h0)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .filt_en(filt_en), .filt_len(filt_len),
        .dout(dout), .rise_pls(rise_pls), .fall_pls(fall_pls)
    );

    jlsemi_util_sync_deglitch_multi #(
        .WIDTH(4), .SYNC_STEP(2), .CNT_W(4), .RST_VAL(4'hA)
    ) dut_a (
        .clk(clk), .rst(rst), .din(din), .filt_en(filt_en), .filt_len(filt_len),
        .dout(dout_a), .rise_pls(rise_a), .fall_pls(fall_a)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 ns so outputs are sampled off the edge.
    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Check all three outputs of the default instance at once.
    task automatic chk_all(input string tag, input logic [3:0] d, input logic [3:0] r,
                           input logic [3:0] f);
        chk({tag, ".dout"}, 32'(dout), 32'(d));
        chk({tag, ".rise"}, 32'(rise_pls), 32'(r));
        chk({tag, ".fall"}, 32'(fall_pls), 32'(f));
    endtask

    // Overall safety net so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        din      = 4'h0;
        filt_en  = 1'b0;
        filt_len = 4'd0;
        clk_n(2);

        // Reset state of both instances.
        chk_all("rst", 4'h0, 4'h0, 4'h0);
        chk("rstA.dout", 32'(dout_a), 32'h0000_000A);
        chk("rstA.pls", 32'({rise_a, fall_a}), 32'h0);
        rst = 1'b0;
        clk_n(1);
        chk("relA.dout", 32'(dout_a), 32'h0000_000A);
        chk("relA.pls", 32'({rise_a, fall_a}), 32'h0);
        chk_all("rel", 4'h0, 4'h0, 4'h0);
        clk_n(5);

        // Test 1: bypass, latency SYNC_STEP+1 = 3 edges.
        din = 4'b0001;
        clk_n(2);
        chk_all("t1.e2", 4'h0, 4'h0, 4'h0);
        clk_n(1);
        chk_all("t1.e3", 4'h1, 4'h1, 4'h0);
        clk_n(1);
        chk_all("t1.e4", 4'h1, 4'h0, 4'h0);
        din = 4'b0000;
        clk_n(3);
        chk_all("t1.fall", 4'h0, 4'h0, 4'h1);
        clk_n(1);

        // Test 4: filter enabled with zero length behaves like bypass.
        filt_en  = 1'b1;
        filt_len = 4'd0;
        din = 4'b0001;
        clk_n(2);
        chk_all("t4.e2", 4'h0, 4'h0, 4'h0);
        clk_n(1);
        chk_all("t4.e3", 4'h1, 4'h1, 4'h0);
        clk_n(1);
        chk_all("t4.e4", 4'h1, 4'h0, 4'h0);
        din = 4'b0000;
        clk_n(4);
        chk_all("t4.idle", 4'h0, 4'h0, 4'h0);

        // Test 2: length 3, a 2-cycle pulse is suppressed.
        filt_len = 4'd3;
        din = 4'b0010;
        clk_n(2);
        din = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            clk_n(1);
            chk_all("t2.glitch", 4'h0, 4'h0, 4'h0);
        end
        // Held level commits at edge 5.
        din = 4'b0010;
        clk_n(4);
        chk_all("t2.e4", 4'h0, 4'h0, 4'h0);
        clk_n(1);
        chk_all("t2.e5", 4'h2, 4'h2, 4'h0);
        clk_n(1);
        chk_all("t2.e6", 4'h2, 4'h0, 4'h0);

        // Test 3: bring dout[2] high, then low 2 / high 1 / low held.
        din = 4'b0110;
        clk_n(8);
        chk_all("t3.pre", 4'h6, 4'h0, 4'h0);
        din = 4'b0010;
        clk_n(2);
        chk_all("t3.e2", 4'h6, 4'h0, 4'h0);
        din = 4'b0110;
        clk_n(1);
        chk_all("t3.e3", 4'h6, 4'h0, 4'h0);
        din = 4'b0010;
        for (int c = 4; c <= 7; c++) begin
            clk_n(1);
            chk_all("t3.run", 4'h6, 4'h0, 4'h0);
        end
        clk_n(1);
        chk_all("t3.e8", 4'h2, 4'h0, 4'h4);
        clk_n(1);
        chk_all("t3.e9", 4'h2, 4'h0, 4'h0);

        // Test 5a: length 8, lower to 4 once the count is at 5.
        filt_len = 4'd8;
        din = 4'b1010;
        clk_n(7);
        chk_all("t5.cnt5", 4'h2, 4'h0, 4'h0);
        filt_len = 4'd4;
        clk_n(1);
        chk_all("t5.lower", 4'hA, 4'h8, 4'h0);
        // Test 5b: length 8, raise to 15 at count 5, commit on sample 15.
        filt_len = 4'd8;
        din = 4'b0010;
        clk_n(7);
        chk_all("t5b.cnt5", 4'hA, 4'h0, 4'h0);
        filt_len = 4'd15;
        clk_n(9);
        chk_all("t5b.e16", 4'hA, 4'h0, 4'h0);
        clk_n(1);
        chk_all("t5b.e17", 4'h2, 4'h0, 4'h8);

        // Test 6: reset mid-count discards progress.
        filt_len = 4'd3;
        din = 4'hF;
        clk_n(4);
        chk_all("t6.mid", 4'h2, 4'h0, 4'h0);
        rst = 1'b1;
        clk_n(1);
        chk_all("t6.rst", 4'h0, 4'h0, 4'h0);
        chk("t6A.dout", 32'(dout_a), 32'h0000_000A);
        chk("t6A.pls", 32'({rise_a, fall_a}), 32'h0);
        rst = 1'b0;
        clk_n(1);
        chk_all("t6.e1", 4'h0, 4'h0, 4'h0);
        chk("t6A.e1", 32'({dout_a, rise_a, fall_a}), 32'h0000_0A00);
        clk_n(3);
        chk_all("t6.e4", 4'h0, 4'h0, 4'h0);
        clk_n(1);
        chk_all("t6.e5", 4'hF, 4'hF, 4'h0);
        clk_n(1);
        chk_all("t6.e6", 4'hF, 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
